// File: rtl/tc_digital_io_bank.sv
// tc_digital_io_bank: per-pad config, registered output path and synchronised, filtered, edge-detected input path.
module tc_digital_io_bank #(
  parameter int NumPads      = 8,
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 4,
  parameter int CntWidth     = $clog2(FilterCycles + 1),
  localparam int IdxW        = NumPads > 1 ? $clog2(NumPads) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_we_i,
  input  logic [IdxW-1:0]        cfg_idx_i,
  input  logic [3:0]             cfg_drive_i,
  input  logic                   cfg_pu_i,
  input  logic                   cfg_pd_i,
  input  logic                   cfg_filt_en_i,
  output logic                   cfg_err_o,
  input  logic [NumPads-1:0]     core_data_i,
  input  logic [NumPads-1:0]     core_oe_i,
  output logic [NumPads-1:0]     core_data_o,
  output logic [NumPads-1:0]     core_rise_o,
  output logic [NumPads-1:0]     core_fall_o,
  output logic [NumPads-1:0]     pad_data_o,
  output logic [NumPads-1:0]     pad_oe_no,
  output logic [4*NumPads-1:0]   pad_drive_o,
  output logic [NumPads-1:0]     pad_pu_o,
  output logic [NumPads-1:0]     pad_pd_o,
  input  logic [NumPads-1:0]     pad_data_i
);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_data_o <= '0;
      pad_oe_no  <= '1;
      cfg_err_o  <= 1'b0;
    end else begin
      pad_data_o <= core_data_i;
      pad_oe_no  <= ~core_oe_i;
      cfg_err_o  <= cfg_we_i && int'(cfg_idx_i) >= NumPads;
    end
  end
  for (genvar n = 0; n < NumPads; n++) begin : g_pad
    logic [SyncStages-1:0] sync;
    logic [CntWidth-1:0]   cnt;
    logic [3:0]            drive;
    logic                  pu, pd, filt_en, f, f_d, s, wr;
    assign s  = sync[SyncStages-1];
    assign wr = cfg_we_i && cfg_idx_i == IdxW'(n);
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync    <= '0;
        cnt     <= '0;
        drive   <= 4'h1;
        pu      <= 1'b0;
        pd      <= 1'b0;
        filt_en <= 1'b0;
        f       <= 1'b0;
        f_d     <= 1'b0;
      end else begin
        sync <= {sync[SyncStages-2:0], pad_data_i[n]};
        f_d  <= f;
        if (!filt_en) begin
          f   <= s;
          cnt <= '0;
        end else if (s == f) begin
          cnt <= '0;
        end else if (cnt == CntWidth'(FilterCycles - 1)) begin
          f   <= s;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // a config write restarts any count in progress; f still follows the old mode this cycle
        if (wr) begin
          drive   <= cfg_drive_i;
          pu      <= cfg_pu_i;
          pd      <= cfg_pd_i & ~cfg_pu_i;
          filt_en <= cfg_filt_en_i;
          cnt     <= '0;
        end
      end
    end
    assign pad_drive_o[4*n +: 4] = drive;
    assign pad_pu_o[n]           = pu;
    assign pad_pd_o[n]           = pd;
    assign core_data_o[n]        = f;
    assign core_rise_o[n]        = f & ~f_d;
    assign core_fall_o[n]        = ~f & f_d;
  end
endmodule

// File: tb/tb_tc_digital_io_bank.sv
// tb_tc_digital_io_bank: directed stimulus with a cycle-stamped scoreboard checked by an independent monitor.
module tb_tc_digital_io_bank;
  localparam int N = 6;
  localparam int S_PDATA = 0, S_OEN = 1, S_DRV = 2, S_PU = 3, S_PD = 4, S_CORE = 5, S_RISE = 6, S_FALL = 7, S_ERR = 8;
  logic clk_i = 1'b0;
  logic rst_i;
  logic cfg_we_i;
  logic [2:0] cfg_idx_i;
  logic [3:0] cfg_drive_i;
  logic cfg_pu_i, cfg_pd_i, cfg_filt_en_i, cfg_err_o;
  logic [N-1:0] core_data_i, core_oe_i, core_data_o, core_rise_o, core_fall_o;
  logic [N-1:0] pad_data_o, pad_oe_no, pad_pu_o, pad_pd_o, pad_data_i;
  logic [4*N-1:0] pad_drive_o;
  tc_digital_io_bank #(.NumPads(N), .SyncStages(2), .FilterCycles(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_drive_i(cfg_drive_i), .cfg_pu_i(cfg_pu_i), .cfg_pd_i(cfg_pd_i),
    .cfg_filt_en_i(cfg_filt_en_i), .cfg_err_o(cfg_err_o),
    .core_data_i(core_data_i), .core_oe_i(core_oe_i), .core_data_o(core_data_o),
    .core_rise_o(core_rise_o), .core_fall_o(core_fall_o), .pad_data_o(pad_data_o),
    .pad_oe_no(pad_oe_no), .pad_drive_o(pad_drive_o), .pad_pu_o(pad_pu_o),
    .pad_pd_o(pad_pd_o), .pad_data_i(pad_data_i)
  );
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;
  typedef struct { int at; int sel; logic [63:0] v; string nm; } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  function automatic logic [63:0] obs(int sel);
    case (sel)
      S_PDATA: return 64'(pad_data_o);
      S_OEN:   return 64'(pad_oe_no);
      S_DRV:   return 64'(pad_drive_o);
      S_PU:    return 64'(pad_pu_o);
      S_PD:    return 64'(pad_pd_o);
      S_CORE:  return 64'(core_data_o);
      S_RISE:  return 64'(core_rise_o);
      S_FALL:  return 64'(core_fall_o);
      default: return 64'(cfg_err_o);
    endcase
  endfunction
  task automatic chk(int at, string nm, int sel, logic [63:0] v);
    exp_t e;
    int i;
    e.at = at; e.sel = sel; e.v = v; e.nm = nm;
    i = 0;
    while (i < q.size() && q[i].at <= at) i++;
    q.insert(i, e);
  endtask
  always @(negedge clk_i) begin
    exp_t e;
    logic [63:0] a;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      a = obs(e.sel);
      checks++;
      if (e.at < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.nm, e.at, cyc);
      end else if (a !== e.v) begin
        errors++;
        $display("FAIL %s @cycle %0d: got %0h expected %0h", e.nm, cyc, a, e.v);
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic cfg(logic [2:0] idx, logic [3:0] drv, logic pu, logic pd, logic fe);
    cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_drive_i = drv;
    cfg_pu_i = pu; cfg_pd_i = pd; cfg_filt_en_i = fe;
  endtask
  int base;
  initial begin
    rst_i = 1'b1;
    cfg_we_i = 1'($urandom); cfg_idx_i = 3'($urandom); cfg_drive_i = 4'($urandom);
    cfg_pu_i = 1'($urandom); cfg_pd_i = 1'($urandom); cfg_filt_en_i = 1'($urandom);
    core_data_i = N'($urandom); core_oe_i = N'($urandom); pad_data_i = N'($urandom);
    tick(3);
    chk(cyc, "rst_pdata", S_PDATA, 0);
    chk(cyc, "rst_oen", S_OEN, 64'h3F);
    chk(cyc, "rst_drive", S_DRV, 64'h111111);
    chk(cyc, "rst_pu", S_PU, 0);
    chk(cyc, "rst_pd", S_PD, 0);
    chk(cyc, "rst_core", S_CORE, 0);
    chk(cyc, "rst_rise", S_RISE, 0);
    chk(cyc, "rst_fall", S_FALL, 0);
    chk(cyc, "rst_err", S_ERR, 0);
    rst_i = 1'b0; cfg_we_i = 1'b0; core_data_i = '0; core_oe_i = '0; pad_data_i = '0;
    for (int i = 1; i <= 3; i++) begin
      chk(cyc + i, "rel_rise", S_RISE, 0);
      chk(cyc + i, "rel_fall", S_FALL, 0);
    end
    cfg(3'd2, 4'hA, 1'b1, 1'b1, 1'b0);
    chk(cyc + 1, "cfg_drive", S_DRV, 64'h111A11);
    chk(cyc + 1, "cfg_pu", S_PU, 64'h04);
    chk(cyc + 1, "cfg_pd_puwins", S_PD, 0);
    chk(cyc + 1, "cfg_noerr", S_ERR, 0);
    tick(1);
    cfg(3'd6, 4'hF, 1'b0, 1'b1, 1'b1);
    chk(cyc + 1, "oor_err", S_ERR, 1);
    chk(cyc + 1, "oor_drive", S_DRV, 64'h111A11);
    chk(cyc + 1, "oor_pu", S_PU, 64'h04);
    chk(cyc + 1, "oor_pd", S_PD, 0);
    chk(cyc + 2, "oor_err_end", S_ERR, 0);
    tick(1);
    cfg_we_i = 1'b0;
    tick(1);
    core_oe_i = 6'h0F; core_data_i = 6'h05;
    chk(cyc, "out_oen_before", S_OEN, 64'h3F);
    chk(cyc + 1, "out_oen", S_OEN, 64'h30);
    chk(cyc + 1, "out_data", S_PDATA, 64'h05);
    tick(2);
    base = cyc; pad_data_i = 6'h01;
    chk(base + 2, "unf_core_early", S_CORE, 0);
    chk(base + 3, "unf_core", S_CORE, 64'h01);
    chk(base + 3, "unf_rise", S_RISE, 64'h01);
    chk(base + 4, "unf_rise_end", S_RISE, 0);
    chk(base + 4, "unf_core_hold", S_CORE, 64'h01);
    tick(6);
    base = cyc; pad_data_i = 6'h00;
    chk(base + 2, "unf_fall_early", S_CORE, 64'h01);
    chk(base + 3, "unf_core_fall", S_CORE, 0);
    chk(base + 3, "unf_fall", S_FALL, 64'h01);
    chk(base + 4, "unf_fall_end", S_FALL, 0);
    tick(6);
    cfg(3'd1, 4'h1, 1'b0, 1'b0, 1'b1);
    tick(1);
    cfg_we_i = 1'b0;
    tick(2);
    base = cyc; pad_data_i = 6'h02;
    for (int i = 1; i <= 9; i++) begin
      chk(base + i, "glitch_core", S_CORE, 0);
      chk(base + i, "glitch_rise", S_RISE, 0);
    end
    tick(3);
    pad_data_i = 6'h00;
    tick(8);
    base = cyc; pad_data_i = 6'h02;
    chk(base + 5, "filt_core_early", S_CORE, 0);
    chk(base + 6, "filt_core", S_CORE, 64'h02);
    chk(base + 6, "filt_rise", S_RISE, 64'h02);
    chk(base + 7, "filt_rise_end", S_RISE, 0);
    tick(8);
    base = cyc; pad_data_i = 6'h00;
    chk(base + 5, "filt_fall_early", S_CORE, 64'h02);
    chk(base + 6, "filt_core_fall", S_CORE, 0);
    chk(base + 6, "filt_fall", S_FALL, 64'h02);
    chk(base + 7, "filt_fall_end", S_FALL, 0);
    tick(8);
    base = cyc; pad_data_i = 6'h02;
    chk(base + 6, "dip_no_early_accept", S_CORE, 0);
    chk(base + 8, "dip_core_early", S_CORE, 0);
    chk(base + 9, "dip_core", S_CORE, 64'h02);
    chk(base + 9, "dip_rise", S_RISE, 64'h02);
    tick(2);
    pad_data_i = 6'h00;
    tick(1);
    pad_data_i = 6'h02;
    tick(10);
    base = cyc; pad_data_i = 6'h00;
    tick(4);
    rst_i = 1'b1; pad_data_i = 6'h02;
    chk(base + 5, "mrst_core", S_CORE, 0);
    chk(base + 5, "mrst_rise", S_RISE, 0);
    chk(base + 5, "mrst_fall", S_FALL, 0);
    chk(base + 5, "mrst_drive", S_DRV, 64'h111111);
    chk(base + 5, "mrst_pu", S_PU, 0);
    chk(base + 5, "mrst_oen", S_OEN, 64'h3F);
    chk(base + 5, "mrst_pdata", S_PDATA, 0);
    chk(base + 7, "mrst_core_early", S_CORE, 0);
    chk(base + 8, "mrst_core_rise", S_CORE, 64'h02);
    chk(base + 8, "mrst_rise_after", S_RISE, 64'h02);
    chk(base + 9, "mrst_rise_end", S_RISE, 0);
    chk(base + 9, "mrst_oen_back", S_OEN, 64'h30);
    tick(1);
    rst_i = 1'b0;
    tick(6);
    cfg(3'd1, 4'h1, 1'b0, 1'b0, 1'b1);
    tick(1);
    cfg_we_i = 1'b0;
    tick(2);
    base = cyc; pad_data_i = 6'h00;
    chk(base + 6, "wr_restart_hold", S_CORE, 64'h02);
    chk(base + 7, "wr_restart_hold2", S_CORE, 64'h02);
    chk(base + 7, "wr_restart_nofall", S_FALL, 0);
    chk(base + 8, "wr_restart_core", S_CORE, 0);
    chk(base + 8, "wr_restart_fall", S_FALL, 64'h02);
    tick(3);
    cfg(3'd1, 4'h1, 1'b0, 1'b0, 1'b1);
    tick(1);
    cfg_we_i = 1'b0;
    tick(8);
    for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      errors += q.size();
      checks += q.size();
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tc_digital_io_bank.md
# tc_digital_io_bank

Parametrised bank controller for `NumPads` bidirectional digital pads; it sits between core logic and a row of digital IO cells.
- Holds per-pad runtime configuration: drive strength, pull-up/down, input filter enable.
- Registers the outbound data and output-enable path.
- Conditions the inbound path with a synchroniser, an optional per-pad glitch filter and rise/fall event detection.

## Interface
Parameters:
- `NumPads`, default 8: number of pads in the bank, ≥1.
- `SyncStages`, default 2: input synchroniser depth, ≥2.
- `FilterCycles`, default 4: consecutive stable cycles needed to accept a filtered input change, ≥1.
- `CntWidth`, default `$clog2(FilterCycles+1)`: filter counter width.

Ports:
- `clk_i`  in  1  clock, single clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `cfg_we_i`  in  1  config write strobe.
- `cfg_idx_i`  in  `$clog2(NumPads)` (min 1)  target pad index.
- `cfg_drive_i`  in  4  drive strength.
- `cfg_pu_i`  in  1  pull-up enable.
- `cfg_pd_i`  in  1  pull-down enable.
- `cfg_filt_en_i`  in  1  glitch filter enable.
- `cfg_err_o`  out  1  one-cycle pulse: write to out-of-range index.
- `core_data_i`  in  `NumPads`  data to drive onto pads.
- `core_oe_i`  in  `NumPads`  1 = drive pad.
- `core_data_o`  out  `NumPads`  conditioned pad input.
- `core_rise_o`  out  `NumPads`  one-cycle rising-edge event.
- `core_fall_o`  out  `NumPads`  one-cycle falling-edge event.
- `pad_data_o`  out  `NumPads`  to IO cell data input.
- `pad_oe_no`  out  `NumPads`  to IO cell, active-low output enable.
- `pad_drive_o`  out  `4*NumPads`  drive strength, pad n at [4n+3:4n].
- `pad_pu_o`  out  `NumPads`  pull-up enables.
- `pad_pd_o`  out  `NumPads`  pull-down enables.
- `pad_data_i`  in  `NumPads`  from IO cell, asynchronous.

## Operation
**Config write**
- When `cfg_we_i`=1 and `cfg_idx_i` < `NumPads`, the write updates that pad's drive, pu, pd and filt_en registers at the clock edge.
- If pu and pd are both set, pu=1 and pd=0 are stored; pull-up wins.
- The write clears that pad's filter counter.
- An index ≥ `NumPads` changes no state and pulses `cfg_err_o` for one cycle.

**Output path**
- `pad_data_o` ← `core_data_i` and `pad_oe_no` ← `~core_oe_i`, both registered with 1 cycle latency.

**Input path, per pad**
- `SyncStages` flop chain produces `s`.
- The filtered register `f` drives `core_data_o`.
- Filter disabled: `f` ← `s` every cycle.
- Filter enabled:
  - If `s`==`f`: counter ← 0.
  - Else if counter == `FilterCycles`-1: `f` ← `s` and counter ← 0.
  - Else: counter increments.
- Any single cycle with `s`==`f` restarts the count, so glitches shorter than `FilterCycles` cycles are discarded.
- `f_d` is a one-cycle delayed copy of `f`.
  - `core_rise_o` = `f & ~f_d`.
  - `core_fall_o` = `~f & f_d`.

**Reset values** (all outputs):
- `pad_data_o`=0, `pad_oe_no`=all 1 (all pads input).
- `pad_drive_o`=4'h1 per pad, `pad_pu_o`=0, `pad_pd_o`=0.
- Filters disabled.
- `core_data_o`=0, `core_rise_o`=0, `core_fall_o`=0, `cfg_err_o`=0.
- Sync chain, `f`, `f_d` and counters are all cleared.

## Timing
- Config write at edge k: new value visible on `pad_*` outputs after edge k.
- Core output: `core_data_i`/`core_oe_i` sampled at edge k appear on pads after edge k.
- Pad input, filter disabled: a change stable before edge k reaches `core_data_o` after edge k+`SyncStages`.
- Pad input, filter enabled: reaches `core_data_o` after edge k+`SyncStages`-1+`FilterCycles`.
- `FilterCycles`=1 gives the same latency as filter disabled.
- Edge pulse is high in the same cycle `core_data_o` first shows the new value, for exactly one cycle.
- Reset mid-operation: all state returns to reset values at the next edge.
  - No edge pulse is generated by the reset itself.
  - If the pad is 1 after reset, the first cycle `f` goes to 1 produces a normal rise pulse.
- Toggling filt_en while a count is in progress: the counter is cleared on that write and the new mode applies from the next cycle.
- Simultaneous `cfg_we_i` and a filter acceptance on the same pad: the counter clear from the write wins, and `f` still updates that cycle.

## Test plan
- **Reset:** assert `rst_i` 3 cycles with random inputs -> every output equals its reset value; no rise/fall pulse on release with `pad_data_i`=0.
- **Config:** write idx 2, drive=4'hA, pu=1, pd=1 -> `pad_drive_o`[11:8]=4'hA, pu[2]=1, pd[2]=0 next cycle. Write idx=`NumPads` -> `cfg_err_o` pulse and no register change.
- **Output:** `core_oe_i`=8'h0F, `core_data_i`=8'h05 -> `pad_oe_no`=8'hF0, `pad_data_o`=8'h05 one cycle later.
- **Unfiltered input:** pad 0 rises -> `core_data_o`[0]=1 after `SyncStages` edges, `core_rise_o`[0] high exactly 1 cycle; falling edge gives a `core_fall_o` pulse.
- **Filter** (`FilterCycles`=4, filt_en=1):
  - 3-cycle high glitch -> no change, no pulse.
  - 4-cycle high -> `core_data_o` rises at `SyncStages`+3 edges.
  - A 1-cycle dip at count 2 restarts the count.
- **Mid-op events:**
  - Reset during an in-progress filter count -> counter and `f` cleared.
  - Config write to the same pad during a count -> count restarts.
